// File: rtl/bsg_zynq_fifo_gearbox.sv
// Word/packet gearbox between the 32-bit Zynq shell CSR FIFOs and packet-wide
// manycore endpoint FIFOs: per-channel serial-to-parallel and parallel-to-serial paths.
module bsg_zynq_fifo_gearbox #(
    parameter int word_width_p   = 32,
    parameter int packet_width_p = 128,
    parameter int num_in_p       = 2,
    parameter int num_out_p      = 2,
    parameter int els_p          = 2,
    parameter int count_width_p  = 16
) (
    input  logic                                aclk_i,
    input  logic                                aresetn_i,

    input  logic [num_in_p*word_width_p-1:0]    ps_word_i,
    input  logic [num_in_p-1:0]                 ps_word_v_i,
    output logic [num_in_p-1:0]                 ps_word_yumi_o,
    input  logic [num_in_p-1:0]                 flush_i,
    output logic [num_in_p*packet_width_p-1:0]  pkt_o,
    output logic [num_in_p-1:0]                 pkt_v_o,
    input  logic [num_in_p-1:0]                 pkt_ready_and_i,

    input  logic [num_out_p*packet_width_p-1:0] pkt_i,
    input  logic [num_out_p-1:0]                pkt_v_i,
    output logic [num_out_p-1:0]                pkt_ready_and_o,
    output logic [num_out_p*word_width_p-1:0]   pl_word_o,
    output logic [num_out_p-1:0]                pl_word_v_o,
    input  logic [num_out_p-1:0]                pl_word_ready_and_i,

    output logic [num_in_p-1:0]                 in_partial_o,
    output logic [num_in_p*count_width_p-1:0]   in_pkt_count_o,
    output logic [num_out_p*count_width_p-1:0]  out_pkt_count_o
);

    localparam int words_lp = (packet_width_p + word_width_p - 1) / word_width_p;
    localparam int idx_w_lp = (words_lp > 1) ? $clog2(words_lp) : 1;
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam int pad_w_lp = words_lp * word_width_p;
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(words_lp - 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Reset-done: every handshake output is held low until the first edge out of reset.
    logic rdy;
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) rdy <= 1'b0;
        else            rdy <= 1'b1;
    end

    for (genvar i = 0; i < num_in_p; i++) begin : in_ch
        logic [idx_w_lp-1:0]       idx;
        logic [pad_w_lp-1:0]       acc;
        logic [pad_w_lp-1:0]       assembled;
        logic [packet_width_p-1:0] mem [els_p];
        logic [ptr_w_lp-1:0]       rd_ptr, wr_ptr;
        logic [cnt_w_lp-1:0]       used;
        logic [count_width_p-1:0]  pkt_count;
        logic [word_width_p-1:0]   word;
        logic                      full, is_last, yumi, enq, valid, deq;

        assign word    = ps_word_i[i*word_width_p +: word_width_p];
        assign full    = (used == cnt_w_lp'(els_p));
        assign is_last = (idx == last_idx_lp);
        // Full is taken before any same-cycle dequeue: the last word never bypasses.
        assign yumi    = rdy & ps_word_v_i[i] & ~flush_i[i] & ~(is_last & full);
        assign enq     = yumi & is_last;
        assign valid   = rdy & (used != '0);
        assign deq     = valid & pkt_ready_and_i[i];

        always_comb begin
            assembled = acc;
            assembled[(words_lp-1)*word_width_p +: word_width_p] = word;
        end

        always_ff @(posedge aclk_i or negedge aresetn_i) begin
            if (!aresetn_i) begin
                idx       <= '0;
                acc       <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                used      <= '0;
                pkt_count <= '0;
            end else begin
                if (flush_i[i]) begin
                    idx <= '0;
                end else if (yumi) begin
                    if (is_last) begin
                        idx       <= '0;
                        wr_ptr    <= ptr_inc(wr_ptr);
                        pkt_count <= pkt_count + count_width_p'(1);
                    end else begin
                        acc[idx*word_width_p +: word_width_p] <= word;
                        idx <= idx + idx_w_lp'(1);
                    end
                end
                if (deq) rd_ptr <= ptr_inc(rd_ptr);
                case ({enq, deq})
                    2'b10:   used <= used + cnt_w_lp'(1);
                    2'b01:   used <= used - cnt_w_lp'(1);
                    default: used <= used;
                endcase
            end
        end

        always_ff @(posedge aclk_i) begin
            if (enq) mem[wr_ptr] <= assembled[packet_width_p-1:0];
        end

        assign ps_word_yumi_o[i]                                 = yumi;
        assign pkt_v_o[i]                                        = valid;
        assign pkt_o[i*packet_width_p +: packet_width_p]         = mem[rd_ptr];
        assign in_partial_o[i]                                   = (idx != '0);
        assign in_pkt_count_o[i*count_width_p +: count_width_p] = pkt_count;
    end

    for (genvar j = 0; j < num_out_p; j++) begin : out_ch
        logic [packet_width_p-1:0] pkt_r;
        logic [pad_w_lp-1:0]       padded;
        logic                      loaded;
        logic [idx_w_lp-1:0]       oidx;
        logic [count_width_p-1:0]  pkt_count;
        logic                      last, word_v, xfer, ready, accept;

        assign last   = (oidx == last_idx_lp);
        assign word_v = rdy & loaded;
        assign xfer   = word_v & pl_word_ready_and_i[j];
        assign ready  = rdy & (~loaded | (last & pl_word_ready_and_i[j]));
        assign accept = ready & pkt_v_i[j];

        always_comb begin
            padded = '0;
            padded[packet_width_p-1:0] = pkt_r;
        end

        // A new packet accepted on the last-word beat overrides the unload.
        always_ff @(posedge aclk_i or negedge aresetn_i) begin
            if (!aresetn_i) begin
                pkt_r     <= '0;
                loaded    <= 1'b0;
                oidx      <= '0;
                pkt_count <= '0;
            end else begin
                if (xfer) begin
                    if (last) begin
                        loaded    <= 1'b0;
                        pkt_count <= pkt_count + count_width_p'(1);
                    end else begin
                        oidx <= oidx + idx_w_lp'(1);
                    end
                end
                if (accept) begin
                    pkt_r  <= pkt_i[j*packet_width_p +: packet_width_p];
                    loaded <= 1'b1;
                    oidx   <= '0;
                end
            end
        end

        assign pkt_ready_and_o[j]                                 = ready;
        assign pl_word_v_o[j]                                     = word_v;
        assign pl_word_o[j*word_width_p +: word_width_p]          = padded[oidx*word_width_p +: word_width_p];
        assign out_pkt_count_o[j*count_width_p +: count_width_p] = pkt_count;
    end

endmodule

// File: tb/tb_bsg_zynq_fifo_gearbox.sv
// Bench for bsg_zynq_fifo_gearbox: directed plan steps plus randomized traffic,
// each cycle compared against a queue-style behavioural model.
module tb_bsg_zynq_fifo_gearbox;
    localparam int W = 4, ELS = 2;

    logic clk = 1'b0, aresetn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   ps_v, flush, pkt_rdy, pkt_v, pl_rdy;
    logic [31:0]  ps_w [2];
    logic [127:0] pkt_in [2];
    logic [63:0]  ps_word, pl_word;
    logic [255:0] pkt_o_w, pkt_i_w;
    logic [1:0]   yumi, pkt_v_w, pkt_rdy_o, pl_v, partial;
    logic [31:0]  in_cnt, out_cnt;
    assign ps_word = {ps_w[1], ps_w[0]};
    assign pkt_i_w = {pkt_in[1], pkt_in[0]};

    bsg_zynq_fifo_gearbox dut (
        .aclk_i(clk), .aresetn_i(aresetn),
        .ps_word_i(ps_word), .ps_word_v_i(ps_v), .ps_word_yumi_o(yumi), .flush_i(flush),
        .pkt_o(pkt_o_w), .pkt_v_o(pkt_v_w), .pkt_ready_and_i(pkt_rdy),
        .pkt_i(pkt_i_w), .pkt_v_i(pkt_v), .pkt_ready_and_o(pkt_rdy_o),
        .pl_word_o(pl_word), .pl_word_v_o(pl_v), .pl_word_ready_and_i(pl_rdy),
        .in_partial_o(partial), .in_pkt_count_o(in_cnt), .out_pkt_count_o(out_cnt)
    );

    // Narrow-counter instance for the wrap check.
    logic [31:0]  d2_word, d2_pl_word;
    logic         d2_v, d2_yumi, d2_flush, d2_pkt_v, d2_pkt_rdy;
    logic         d2_opkt_v, d2_opkt_rdy, d2_pl_v, d2_pl_rdy, d2_partial;
    logic [127:0] d2_pkt, d2_opkt;
    logic [1:0]   d2_in_cnt, d2_out_cnt;

    bsg_zynq_fifo_gearbox #(.num_in_p(1), .num_out_p(1), .count_width_p(2)) dut2 (
        .aclk_i(clk), .aresetn_i(aresetn),
        .ps_word_i(d2_word), .ps_word_v_i(d2_v), .ps_word_yumi_o(d2_yumi), .flush_i(d2_flush),
        .pkt_o(d2_pkt), .pkt_v_o(d2_pkt_v), .pkt_ready_and_i(d2_pkt_rdy),
        .pkt_i(d2_opkt), .pkt_v_i(d2_opkt_v), .pkt_ready_and_o(d2_opkt_rdy),
        .pl_word_o(d2_pl_word), .pl_word_v_o(d2_pl_v), .pl_word_ready_and_i(d2_pl_rdy),
        .in_partial_o(d2_partial), .in_pkt_count_o(d2_in_cnt), .out_pkt_count_o(d2_out_cnt)
    );

    int npass = 0, ntotal = 0;

    // Behavioural model: words held per input channel, queue of finished packets,
    // words left to send per output channel.
    bit           rdy_m;
    int           np [2], bh [2], bc [2], cin [2], orem [2], cout [2];
    logic [127:0] acc [2], cur [2];
    logic [127:0] bq [2][ELS];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic mreset();
        rdy_m = 1'b0;
        for (int i = 0; i < 2; i++) begin
            np[i] = 0; bh[i] = 0; bc[i] = 0; cin[i] = 0; orem[i] = 0; cout[i] = 0;
            acc[i] = '0; cur[i] = '0;
        end
    endtask

    task automatic step();
        bit ey [2], ev [2], er [2], eo [2];
        logic [127:0] t;
        if (!aresetn) mreset();
        #1;
        for (int i = 0; i < 2; i++) begin
            ey[i] = rdy_m && ps_v[i] && !flush[i] && !(np[i] == W-1 && bc[i] == ELS);
            ev[i] = rdy_m && bc[i] > 0;
            chk($sformatf("yumi%0d", i), 128'(yumi[i]), 128'(ey[i]));
            chk($sformatf("pkt_v%0d", i), 128'(pkt_v_w[i]), 128'(ev[i]));
            if (ev[i]) chk($sformatf("pkt%0d", i), pkt_o_w[i*128 +: 128], bq[i][bh[i]]);
            chk($sformatf("partial%0d", i), 128'(partial[i]), 128'(np[i] != 0));
            chk($sformatf("in_cnt%0d", i), 128'(in_cnt[i*16 +: 16]), 128'(cin[i] & 32'hFFFF));
        end
        for (int j = 0; j < 2; j++) begin
            er[j] = rdy_m && (orem[j] == 0 || (orem[j] == 1 && pl_rdy[j]));
            eo[j] = rdy_m && orem[j] > 0;
            chk($sformatf("pkt_rdy%0d", j), 128'(pkt_rdy_o[j]), 128'(er[j]));
            chk($sformatf("pl_v%0d", j), 128'(pl_v[j]), 128'(eo[j]));
            if (eo[j]) begin
                t = cur[j] >> (32 * (W - orem[j]));
                chk($sformatf("pl_word%0d", j), 128'(pl_word[j*32 +: 32]), 128'(t[31:0]));
            end
            chk($sformatf("out_cnt%0d", j), 128'(out_cnt[j*16 +: 16]), 128'(cout[j] & 32'hFFFF));
        end
        for (int i = 0; i < 2; i++) begin
            if (ev[i] && pkt_rdy[i]) begin bh[i] = (bh[i] + 1) % ELS; bc[i]--; end
            if (flush[i]) begin
                np[i] = 0; acc[i] = '0;
            end else if (ey[i]) begin
                acc[i] = acc[i] | (128'(ps_w[i]) << (32 * np[i]));
                if (np[i] == W-1) begin
                    bq[i][(bh[i] + bc[i]) % ELS] = acc[i];
                    bc[i]++; cin[i]++; np[i] = 0; acc[i] = '0;
                end else np[i]++;
            end
        end
        for (int j = 0; j < 2; j++) begin
            if (eo[j] && pl_rdy[j]) begin orem[j]--; if (orem[j] == 0) cout[j]++; end
            if (er[j] && pkt_v[j]) begin cur[j] = pkt_in[j]; orem[j] = W; end
        end
        @(posedge clk);
        if (aresetn) rdy_m = 1'b1;
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 2; i++) begin
            ps_v[i]    = $urandom_range(0, 3) != 0;
            ps_w[i]    = $urandom;
            flush[i]   = $urandom_range(0, 15) == 0;
            pkt_rdy[i] = $urandom_range(0, 1) != 0;
            pkt_v[i]   = $urandom_range(0, 1) != 0;
            pkt_in[i]  = {$urandom, $urandom, $urandom, $urandom};
            pl_rdy[i]  = $urandom_range(0, 2) != 0;
        end
    endtask

    logic [31:0] ew [8] = '{32'h89ABCDEF, 32'h01234567, 32'hCAFEF00D, 32'hDEADBEEF,
                            32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

    initial begin
        ps_v = '0; flush = '0; pkt_rdy = '0; pkt_v = '0; pl_rdy = '0;
        ps_w[0] = '0; ps_w[1] = '0; pkt_in[0] = '0; pkt_in[1] = '0;
        d2_word = '0; d2_v = 0; d2_flush = 0; d2_pkt_rdy = 0;
        d2_opkt = '0; d2_opkt_v = 0; d2_pl_rdy = 0;
        mreset();
        @(negedge clk);
        step(); step();

        // Release: handshakes stay low for the first cycle even with requests pending.
        aresetn = 1'b1;
        ps_v = 2'b11; pkt_v = 2'b11; pkt_rdy = 2'b11; pl_rdy = 2'b11;
        step();
        ps_v = '0; pkt_v = '0; pkt_rdy = '0; pl_rdy = '0;

        // Four words on channel 0 assemble into one packet.
        ps_v[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin ps_w[0] = 32'h11 * (k + 1); step(); end
        ps_v[0] = 1'b0;
        #1;
        chk("t1_pkt", pkt_o_w[127:0], 128'h00000044_00000033_00000022_00000011);
        chk("t1_v", 128'(pkt_v_w[0]), 128'd1);
        chk("t1_cnt", 128'(in_cnt[15:0]), 128'd1);
        pkt_rdy[0] = 1'b1; step(); pkt_rdy[0] = 1'b0;

        // Back-pressure: two packets buffered, last word of the third held off.
        ps_v[0] = 1'b1;
        for (int k = 0; k < 11; k++) begin ps_w[0] = 32'h100 + k; step(); end
        ps_w[0] = 32'h10B;
        #1;
        chk("t2_blocked", 128'(yumi[0]), 128'd0);
        chk("t2_partial", 128'(partial[0]), 128'd1);
        step();
        pkt_rdy[0] = 1'b1; step(); pkt_rdy[0] = 1'b0;
        #1;
        chk("t2_resume", 128'(yumi[0]), 128'd1);
        step();
        ps_v[0] = 1'b0; pkt_rdy[0] = 1'b1;
        repeat (4) step();
        pkt_rdy[0] = 1'b0;

        // Flush of a partial packet.
        ps_v[0] = 1'b1;
        ps_w[0] = 32'hA0; step(); ps_w[0] = 32'hB0; step();
        #1;
        chk("t3_partial_pre", 128'(partial[0]), 128'd1);
        flush[0] = 1'b1; step(); flush[0] = 1'b0;
        #1;
        chk("t3_partial_post", 128'(partial[0]), 128'd0);
        for (int k = 0; k < 4; k++) begin ps_w[0] = 32'hA + k; step(); end
        ps_v[0] = 1'b0;
        #1;
        chk("t3_pkt", pkt_o_w[127:0], 128'h0000000D_0000000C_0000000B_0000000A);
        chk("t3_cnt", 128'(in_cnt[15:0]), 128'd5);
        pkt_rdy[0] = 1'b1; step(); pkt_rdy[0] = 1'b0;

        // Back-to-back serialisation on output channel 1.
        pl_rdy = 2'b11; pkt_v[1] = 1'b1;
        pkt_in[1] = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        step();
        pkt_in[1] = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("t4_v%0d", k), 128'(pl_v[1]), 128'd1);
            chk($sformatf("t4_word%0d", k), 128'(pl_word[63:32]), 128'(ew[k]));
            step();
            if (k == 3) pkt_v[1] = 1'b0;
        end
        #1;
        chk("t4_cnt", 128'(out_cnt[31:16]), 128'd2);
        chk("t4_idle", 128'(pl_v[1]), 128'd0);

        // Randomized traffic on every channel.
        for (int n = 0; n < 400; n++) begin randomize_inputs(); step(); end

        // Asynchronous reset in the middle of traffic.
        randomize_inputs(); ps_v = 2'b11; pkt_v = 2'b11;
        #2; aresetn = 1'b0; #1;
        chk("rst_yumi", 128'(yumi), 128'd0);
        chk("rst_pkt_v", 128'(pkt_v_w), 128'd0);
        chk("rst_pkt_rdy", 128'(pkt_rdy_o), 128'd0);
        chk("rst_pl_v", 128'(pl_v), 128'd0);
        chk("rst_partial", 128'(partial), 128'd0);
        chk("rst_in_cnt", 128'(in_cnt), 128'd0);
        chk("rst_out_cnt", 128'(out_cnt), 128'd0);
        mreset();
        @(negedge clk);
        step(); step();
        aresetn = 1'b1;
        step();
        for (int n = 0; n < 100; n++) begin randomize_inputs(); step(); end

        // Counter wrap on the 2-bit instance: five packets read back as 1.
        d2_v = 1'b1; d2_pkt_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            d2_word = 32'h500 + k;
            #1;
            chk($sformatf("d2_yumi%0d", k), 128'(d2_yumi), 128'd1);
            @(posedge clk); @(negedge clk);
        end
        d2_v = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        chk("d2_wrap", 128'(d2_in_cnt), 128'd1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/bsg_zynq_fifo_gearbox.md
Name: bsg_zynq_fifo_gearbox

Overview:
- Parametrised word/packet gearbox between the Zynq PL-shell 32-bit CSR FIFOs and packet-wide manycore endpoint FIFOs.
- Provides num_in_p independent serial-to-parallel channels (PS→PL) with els_p-deep packet buffering.
- Provides num_out_p independent parallel-to-serial channels (PL→PS).
- Adds per-channel partial-packet flush, partial-packet status and wrapping packet counters for host-side debug and recovery.

Parameters:
- word_width_p, 32, shell FIFO word width.
- packet_width_p, 128, endpoint packet width. W = CDIV(packet_width_p, word_width_p) words per packet.
- num_in_p, 2, number of PS→PL channels (≥1).
- num_out_p, 2, number of PL→PS channels (≥1).
- els_p, 2, assembled-packet buffer depth per input channel (≥1).
- count_width_p, 16, packet counter width.

Ports:
- aclk_i  in  1  clock.
- aresetn_i  in  1  reset; asynchronous, active-low.
- ps_word_i  in  num_in_p*word_width_p  words from shell PS→PL FIFOs.
- ps_word_v_i  in  num_in_p  word valid.
- ps_word_yumi_o  out  num_in_p  word consumed this cycle.
- flush_i  in  num_in_p  discard the partially assembled packet.
- pkt_o  out  num_in_p*packet_width_p  assembled packets.
- pkt_v_o  out  num_in_p  packet valid.
- pkt_ready_and_i  in  num_in_p  consumer ready.
- pkt_i  in  num_out_p*packet_width_p  packets to serialise.
- pkt_v_i  in  num_out_p  packet valid.
- pkt_ready_and_o  out  num_out_p  gearbox ready.
- pl_word_o  out  num_out_p*word_width_p  words to shell PL→PS FIFOs.
- pl_word_v_o  out  num_out_p  word valid.
- pl_word_ready_and_i  in  num_out_p  shell FIFO ready.
- in_partial_o  out  num_in_p  input channel holds 1..W-1 words.
- in_pkt_count_o  out  num_in_p*count_width_p  packets assembled.
- out_pkt_count_o  out  num_out_p*count_width_p  packets fully serialised.

Behaviour:
Reset and reset-done
- While aresetn_i=0: all word indices 0, packet buffers and registers empty, counters 0, reset-done flag rdy=0.
- While rdy=0, every handshake output (yumi, v, ready_and) is 0.
- rdy sets on the first aclk_i rising edge with aresetn_i=1. A mid-operation reset drops all in-flight words and packets.

Input channel i (serial-to-parallel)
- Word index idx cycles 0..W-1.
- Word k occupies bits [k*word_width_p +: word_width_p]; bits of the last word above packet_width_p are dropped.
- ps_word_yumi_o[i] = rdy & v & ~flush & ~(idx==W-1 & buffer full).
- Buffer full is evaluated before any same-cycle dequeue (no bypass).
- On yumi with idx<W-1: store the word, idx++.
- On yumi with idx==W-1: enqueue the completed packet, idx←0, in_pkt_count++.
- Packet appears on pkt_o/pkt_v_o the cycle after the last word is accepted; the buffer is FIFO order.
- Dequeue occurs on pkt_v_o & pkt_ready_and_i.
- flush_i: idx←0, partial words discarded, no word consumed that cycle. Buffered complete packets and counters are unaffected. Flush with idx==0 is a no-op.
- in_partial_o = (idx≠0).
- Channels are fully independent; no cross-channel ordering.

Output channel j (parallel-to-serial)
- One packet register, a loaded flag and word index oidx.
- pkt_ready_and_o = rdy & (~loaded | (oidx==W-1 & pl_word_ready_and_i)), allowing back-to-back packets with no bubble.
- Accepting a packet sets loaded and oidx←0. The first word is valid the next cycle.
- pl_word_v_o = loaded; pl_word_o = word oidx.
- On v & ready: oidx++. On the last word, loaded←0 unless a new packet is accepted the same cycle, and out_pkt_count++.

Counters
- Counters wrap modulo 2^count_width_p.

Test Plan:
- Reset, then 4 words 0x11,0x22,0x33,0x44 on ch0 back-to-back → 4 yumis; one cycle later pkt_o[0]=0x00000044_00000033_00000022_00000011, pkt_v_o=1; in_pkt_count_o[0]=1.
- Hold pkt_ready_and_i[0]=0 and stream 12 words → 2 packets buffered; 4th word of packet 3 not yumi'd and in_partial_o=1. Pulse ready → word accepted on the following cycle.
- Feed 2 words, assert flush_i[0] for 1 cycle, then 4 words 0xA..0xD → single packet 0xD_C_B_A; in_partial_o shows 1 before flush, 0 after; count +1 only.
- pkt_i[1]=0xDEADBEEF_CAFEF00D_01234567_89ABCDEF with ready held 1, second packet presented immediately → words 0x89ABCDEF, 0x01234567, 0xCAFEF00D, 0xDEADBEEF, then the next packet's word 0 on the following cycle with no gap; out_pkt_count_o[1]=2.
- Random pl_word_ready_and_i stalls on both output channels → word order preserved; pkt_ready_and_o never 1 while loaded and not on the last word.
- Assert aresetn_i=0 mid-packet on every channel → all valid/yumi/ready outputs 0 immediately, stay 0 until the first edge after release; counters 0; no stale words emitted.
- With count_width_p=2, send 5 packets → in_pkt_count_o reads 1.
